// File: rtl/writeback_queue.sv
// writeback_queue
// Buffers destination-register writes from the load and ALU paths in a small
// circular FIFO. It drains the FIFO one entry per cycle into the register
// file's single write port, through registered RegWrite/RD/WriteData.
// It also reports whether a write is still pending to a source register, so
// decode can stall on a read-after-write hazard.
//
// Handshake: an offer on a path is taken at a rising edge when both its valid
// and its ready are high on that edge. The ready signals depend only on
// registered state and on the reset pin, never on the valid of the same path.
// mem_ready ignores alu_valid. alu_ready is also low whenever mem_valid is
// high, because the load path has fixed priority.
//
// Ports:
//   clk, reset                     clock; asynchronous active-low reset
//   mem_valid/mem_rd/mem_data      load result offer, mem_ready accept
//   alu_valid/alu_rd/alu_data      ALU result offer, alu_ready accept
//   wb_hold                        block draining on this edge
//   RegWrite/RD/WriteData          registered register-file write side
//   chk_rs1/chk_rs2                source registers to check
//   busy_rs1/busy_rs2              write pending to the checked register
//   count                          current queue occupancy
module writeback_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_valid,
    input  logic [4:0]               mem_rd,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     wb_hold,
    output logic                     RegWrite,
    output logic [4:0]               RD,
    output logic [DATA_W-1:0]        WriteData,
    input  logic [4:0]               chk_rs1,
    input  logic [4:0]               chk_rs2,
    output logic                     busy_rs1,
    output logic                     busy_rs2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [4:0]        rd_mem_q   [DEPTH];
    logic [4:0]        rd_mem_d   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];
    logic              reg_write_q, reg_write_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              space;
    logic              accept_mem;
    logic              accept_alu;
    logic [4:0]        in_rd;
    logic [DATA_W-1:0] in_data;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  entry_live;
    logic              hit1, hit2;

    // Space is derived from the reset pin as well as from state, so both
    // readies read 0 for as long as reset is held.
    assign space      = reset && (count_q < DEPTH_C);
    assign mem_ready  = space;
    assign alu_ready  = space && !mem_valid;
    assign accept_mem = mem_valid && space;
    assign accept_alu = alu_valid && alu_ready;
    assign in_rd      = accept_mem ? mem_rd   : alu_rd;
    assign in_data    = accept_mem ? mem_data : alu_data;
    // A write to x0 completes its handshake but never enters the queue.
    assign push       = (accept_mem || accept_alu) && (in_rd != 5'd0);
    assign pop        = (count_q != '0) && !wb_hold;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_mem_d    = rd_mem_q;
        data_mem_d  = data_mem_q;
        reg_write_d = 1'b0;
        rd_out_d    = rd_out_q;
        wdata_d     = wdata_q;
        if (push) begin
            rd_mem_d[wr_ptr_q]   = in_rd;
            data_mem_d[wr_ptr_q] = in_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            reg_write_d = 1'b1;
            rd_out_d    = rd_mem_q[rd_ptr_q];
            wdata_d     = data_mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            reg_write_q <= 1'b0;
            rd_out_q    <= '0;
            wdata_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            reg_write_q <= reg_write_d;
            rd_out_q    <= rd_out_d;
            wdata_q     <= wdata_d;
            rd_mem_q    <= rd_mem_d;
            data_mem_q  <= data_mem_d;
        end
    end

    // Slot g is occupied when its distance from the read pointer, taken
    // modulo DEPTH, is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_live
        logic [PTR_W-1:0] offs;
        assign offs          = PTR_W'(g) - rd_ptr_q;
        assign entry_live[g] = ({1'b0, offs} < count_q);
    end

    // A register is busy while its write sits in the queue, and also while
    // that write is on the output registers.
    always_comb begin
        hit1 = reg_write_q && (rd_out_q == chk_rs1);
        hit2 = reg_write_q && (rd_out_q == chk_rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_live[i] && (rd_mem_q[i] == chk_rs1)) hit1 = 1'b1;
            if (entry_live[i] && (rd_mem_q[i] == chk_rs2)) hit2 = 1'b1;
        end
    end

    assign busy_rs1  = hit1 && (chk_rs1 != 5'd0);
    assign busy_rs2  = hit2 && (chk_rs2 != 5'd0);
    assign RegWrite  = reg_write_q;
    assign RD        = rd_out_q;
    assign WriteData = wdata_q;
    assign count     = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue. The model is a queue of pending writes plus the
// expected write-port registers. It is advanced at each rising edge from
// the inputs present on that edge.
module tb_writeback_queue;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_valid, alu_valid, wb_hold;
    logic [4:0]        mem_rd, alu_rd, chk_rs1, chk_rs2;
    logic [DATA_W-1:0] mem_data, alu_data;
    logic              mem_ready, alu_ready, RegWrite, busy_rs1, busy_rs2;
    logic [4:0]        RD;
    logic [DATA_W-1:0] WriteData;
    logic [2:0]        count;

    int total = 0;
    int bad   = 0;

    // model state
    logic [4:0]        m_rd_q[$];
    logic [DATA_W-1:0] m_data_q[$];
    logic              m_rw;
    logic [4:0]        m_rd;
    logic [DATA_W-1:0] m_wd;
    // RD values seen on the write port, in order
    logic [4:0]        seen_q[$];

    writeback_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .wb_hold(wb_hold), .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic m_busy(input logic [4:0] c);
        if (c == 5'd0) return 1'b0;
        foreach (m_rd_q[i]) if (m_rd_q[i] == c) return 1'b1;
        return m_rw && (m_rd == c);
    endfunction

    task automatic model_clear();
        m_rd_q.delete();
        m_data_q.delete();
        m_rw = 1'b0;
        m_rd = '0;
        m_wd = '0;
    endtask

    task automatic compare_all();
        logic sp;
        sp = reset && (m_rd_q.size() < DEPTH);
        check("mem_ready", 64'(mem_ready), 64'(sp));
        check("alu_ready", 64'(alu_ready), 64'(sp && !mem_valid));
        check("RegWrite",  64'(RegWrite),  64'(m_rw));
        check("RD",        64'(RD),        64'(m_rd));
        check("WriteData", WriteData,      m_wd);
        check("count",     64'(count),     64'(m_rd_q.size()));
        check("busy_rs1",  64'(busy_rs1),  64'(m_busy(chk_rs1)));
        check("busy_rs2",  64'(busy_rs2),  64'(m_busy(chk_rs2)));
    endtask

    task automatic model_edge();
        int  sz;
        logic sp;
        if (!reset) begin
            model_clear();
        end else begin
            sz = m_rd_q.size();
            sp = sz < DEPTH;
            if (sz > 0 && !wb_hold) begin
                m_rw = 1'b1;
                m_rd = m_rd_q.pop_front();
                m_wd = m_data_q.pop_front();
            end else begin
                m_rw = 1'b0;
            end
            if (sp && mem_valid) begin
                if (mem_rd != 5'd0) begin
                    m_rd_q.push_back(mem_rd);
                    m_data_q.push_back(mem_data);
                end
            end else if (sp && alu_valid) begin
                if (alu_rd != 5'd0) begin
                    m_rd_q.push_back(alu_rd);
                    m_data_q.push_back(alu_data);
                end
            end
        end
    endtask

    // One clock cycle: compare before the edge, advance the model at the
    // edge, and record any write the port presents after it.
    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
        if (RegWrite === 1'b1) seen_q.push_back(RD);
    endtask

    task automatic idle(input int n);
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer_alu(input logic [4:0] rd, input logic [DATA_W-1:0] data);
        logic r;
        logic done;
        done      = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = data;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            r = alu_ready;
            step();
            done = r;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL offer_timeout actual=%0d required=accepted", rd);
        end
        alu_valid = 1'b0;
    endtask

    task automatic check_seq(input string name, input int first, input int n);
        check({name, "_len"}, 64'(seen_q.size()), 64'(n));
        for (int k = 0; k < n && k < seen_q.size(); k++)
            check($sformatf("%s_%0d", name, k), 64'(seen_q[k]), 64'(first + k));
    endtask

    initial begin
        reset = 1'b0;
        mem_valid = 0; alu_valid = 0; wb_hold = 0;
        mem_rd = 0; alu_rd = 0; mem_data = 0; alu_data = 0;
        chk_rs1 = 0; chk_rs2 = 0;
        model_clear();
        #2;
        check("rst_mem_ready", 64'(mem_ready), 0);
        check("rst_alu_ready", 64'(alu_ready), 0);
        check("rst_RegWrite",  64'(RegWrite),  0);
        check("rst_count",     64'(count),     0);
        step();
        reset = 1'b1;

        // Single ALU write: RegWrite two edges after the accept.
        chk_rs1 = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        #1;
        check("t1_alu_ready", 64'(alu_ready), 1);
        check("t1_busy_pre",  64'(busy_rs1),  0);
        step();
        alu_valid = 1'b0;
        check("t1_count",     64'(count),     1);
        check("t1_busy_acc",  64'(busy_rs1),  1);
        check("t1_rw_n1",     64'(RegWrite),  0);
        step();
        check("t1_rw_n2",     64'(RegWrite),  1);
        check("t1_rd",        64'(RD),        5);
        check("t1_wd",        WriteData,      64'h1234);
        check("t1_busy_wr",   64'(busy_rs1),  1);
        step();
        check("t1_rw_after",  64'(RegWrite),  0);
        check("t1_busy_done", 64'(busy_rs1),  0);

        // Hold fills the queue; a fifth offer waits until the hold is released.
        seen_q.delete();
        wb_hold = 1'b1;
        for (int k = 1; k <= 4; k++) offer_alu(5'(k), 64'(k * 16));
        check("t2_count_full", 64'(count), 4);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h55;
        step();
        check("t2_alu_ready_full", 64'(alu_ready), 0);
        check("t2_count_still",    64'(count),     4);
        wb_hold = 1'b0;
        offer_alu(5'd5, 64'h55);
        idle(6);
        check_seq("t2_order", 1, 5);

        // Load path wins when both are offered.
        seen_q.delete();
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h77;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 64'h88;
        #1;
        check("t3_alu_ready", 64'(alu_ready), 0);
        check("t3_mem_ready", 64'(mem_ready), 1);
        step();
        mem_valid = 1'b0;
        step();
        idle(4);
        check_seq("t3_order", 7, 2);

        // Write to x0 is consumed but never queued or written.
        seen_q.delete();
        chk_rs1 = 5'd0;
        offer_alu(5'd0, 64'hFFFF);
        check("t4_count", 64'(count), 0);
        check("t4_busy0", 64'(busy_rs1), 0);
        idle(3);
        check("t4_no_write", 64'(seen_q.size()), 0);

        // Accept and pop on one edge at count=3.
        seen_q.delete();
        wb_hold = 1'b1;
        for (int k = 9; k <= 11; k++) offer_alu(5'(k), 64'(k));
        check("t5_count3", 64'(count), 3);
        wb_hold = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'd12;
        step();
        alu_valid = 1'b0;
        check("t5_count_same", 64'(count), 3);
        check("t5_rd", 64'(RD), 9);
        idle(6);
        check_seq("t5_order", 9, 4);

        // Twelve writes back to back wrap both pointers several times.
        seen_q.delete();
        for (int k = 1; k <= 12; k++) offer_alu(5'(k), 64'($urandom));
        idle(4);
        check_seq("t5_wrap", 1, 12);

        // Reset mid-operation drops everything immediately.
        wb_hold = 1'b1;
        for (int k = 20; k <= 22; k++) offer_alu(5'(k), 64'(k));
        wb_hold = 1'b0;
        chk_rs1 = 5'd21;
        step();
        check("t6_count2", 64'(count),    2);
        check("t6_rw1",    64'(RegWrite), 1);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check("t6_rw0",    64'(RegWrite),  0);
        check("t6_rd0",    64'(RD),        0);
        check("t6_wd0",    WriteData,      0);
        check("t6_count0", 64'(count),     0);
        check("t6_mready", 64'(mem_ready), 0);
        check("t6_aready", 64'(alu_ready), 0);
        check("t6_busy",   64'(busy_rs1),  0);
        step();
        reset = 1'b1;
        seen_q.delete();
        idle(5);
        check("t6_no_stale", 64'(seen_q.size()), 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            mem_valid = ($urandom_range(0, 3) == 0);
            mem_rd    = 5'($urandom_range(0, 7));
            mem_data  = {$urandom, $urandom};
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = {$urandom, $urandom};
            wb_hold   = ($urandom_range(0, 3) == 0);
            chk_rs1   = 5'($urandom_range(0, 7));
            chk_rs2   = 5'($urandom_range(0, 7));
            step();
        end
        wb_hold = 1'b0;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers destination-register writes from the ALU and load paths and drains them, one per cycle, into the register file's single write port. It drives the `RegWrite`/`RD`/`WriteData` write side of the register file in the pipelined core. It also reports per-register pending-write status so decode can stall on a read-after-write hazard.

## Interface

Parameters:
- `DATA_W`, 64, width of a register write.
- `DEPTH`, 4, queue entries; a power of two, at least 2.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  load result offered.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  DATA_W  load result.
- `mem_ready`  out  1  load result accepted this edge if `mem_valid`.
- `alu_valid`  in  1  ALU result offered.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  DATA_W  ALU result.
- `alu_ready`  out  1  ALU result accepted this edge if `alu_valid`.
- `wb_hold`  in  1  block draining this cycle (write port borrowed elsewhere).
- `RegWrite`  out  1  register-file write enable, registered.
- `RD`  out  5  register-file write address, registered.
- `WriteData`  out  DATA_W  register-file write data, registered.
- `chk_rs1`, `chk_rs2`  in  5 each  source registers to check.
- `busy_rs1`, `busy_rs2`  out  1 each  write pending to the checked register.
- `count`  out  log2(DEPTH)+1  current queue occupancy.

## Operation

- The queue is a circular FIFO with read and write pointers of log2(DEPTH) bits, wrapping at DEPTH, and an occupancy counter.
- Space condition: `space` = reset deasserted AND `count` < DEPTH. It depends on registered state only, not on `wb_hold`.
- Ready rules:
  - `mem_ready` = `space`. The load path has fixed priority.
  - `alu_ready` = `space` AND NOT `mem_valid`.
- Accept: at most one entry is accepted per edge.
  - An accepted entry with rd = 0 completes its handshake but is discarded; the pointer and count are unchanged.
  - Any other accepted entry is written at the write pointer, and the write pointer advances.
- Pop: on an edge where `count` > 0 and `wb_hold` = 0:
  - the head entry loads into the output registers and `RegWrite` is set to 1;
  - the read pointer advances.
- No pop: on any other edge, `RegWrite` is cleared to 0. `RD` and `WriteData` hold their last values.
- Simultaneous accept and pop: `count` is unchanged. This is legal at any occupancy, including DEPTH-1.
- Full: `count` = DEPTH means both readies are 0. No entry is dropped or overwritten.
- Busy: `busy_rsX` = 1 when both of these hold:
  - `chk_rsX` ≠ 0;
  - `chk_rsX` matches the rd of any occupied queue entry, OR (`RegWrite` = 1 AND `RD` = `chk_rsX`).
  - Otherwise `busy_rsX` = 0. It is combinational from state and `chk_rsX`.
- Ordering: writes reach the register file in acceptance order. If two writes target the same rd, the later one wins.

## Timing

- Reset asserted (`reset` = 0), asynchronous:
  - pointers and `count` go to 0;
  - `RegWrite` = 0, `RD` = 0, `WriteData` = 0;
  - `busy_rs1` = `busy_rs2` = 0;
  - `mem_ready` = `alu_ready` = 0 while reset is held.
- Reset mid-operation discards all queued and in-flight writes. `RegWrite` drops immediately, with no partial write.
- First edge after reset release: both readies are 1.
- Latency for an empty queue with no hold:
  - entry accepted at edge N;
  - popped at edge N+1, so `RegWrite` is high during cycle N+1;
  - register file writes at edge N+2.
- `RegWrite` is high for exactly one cycle per popped entry. Back-to-back pops give consecutive high cycles.
- `wb_hold` is sampled at the edge. Hold asserted before edge N means `RegWrite` = 0 in the cycle after edge N.
- `busy` for a register covers from the edge that accepts its write through the cycle where `RegWrite` presents it. It clears after the writing edge.
- Throughput: sustained one accept and one pop per edge with no stalls.

## Test plan

- Reset, then a single ALU write rd=5, data=0x1234 with hold=0 -> `RegWrite` high in exactly one cycle, two edges after accept, with `RD`=5 and `WriteData`=0x1234. `busy_rs1` (chk=5) is 1 from the accept until after that cycle.
- `wb_hold`=1, then 5 ALU writes rd=1..5 offered (DEPTH=4) -> 4 accepted, `count`=4, `alu_ready`=0 for the fifth. Release hold -> RD sequence 1,2,3,4 in consecutive cycles, then rd=5 is accepted and written.
- `mem_valid` and `alu_valid` both asserted, rd=7 and rd=8 -> mem entry taken first and `alu_ready`=0 that edge; writes appear as RD 7 then 8.
- ALU write with rd=0, data=0xFFFF -> handshake completes, `count` stays 0, `RegWrite` never asserts, `busy` with chk=0 stays 0.
- Queue at `count`=3, hold=0, accept and pop on the same edge -> `count` stays 3. Pointers wrap past DEPTH-1 with order preserved over 12 writes.
- `reset` pulsed low while `count`=2 and `RegWrite`=1 -> all outputs go to 0 immediately. After release, no stale write appears.
